gray_port_arbiter: RTL and testbench

Two-requester arbiter for the single gray-image memory read port, so two pixel engines can share one image store. Examples of such engines are the LBP engine and a second neighbourhood filter. It grants one read per cycle, supports locked bursts for 3x3 window fetches, and bounds burst length so neither requester starves. It drives the memory address and routes returned data to the owning requester with a fixed latency.

---
 rtl/gray_port_arbiter_if.sv | 34 +++
 rtl/gray_port_arbiter.sv | 134 +++++++++++++
 tb/tb_gray_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_port_arbiter_if.sv
// Signal bundle between two pixel engines, the gray-image port arbiter and the
// image store. The arbiter takes the slave view; the engines/store take the master view.
interface gray_port_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          gray_ready;
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          lock0;
  logic          lock1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;

  modport slave (
    input  gray_ready, req0, req1, addr0, addr1, lock0, lock1, mem_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_req, mem_addr, busy
  );

  modport master (
    output gray_ready, req0, req1, addr0, addr1, lock0, lock1, mem_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_req, mem_addr, busy
  );
endinterface

// File: rtl/gray_port_arbiter.sv
// Two-requester arbiter for the single gray-image read port: round-robin with
// locked bursts bounded by MAX_BURST, registered memory strobe, tagged data return.
module gray_port_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_BURST = 9
) (
  input  logic               clk,
  input  logic               reset,
  gray_port_arbiter_if.slave bus
);
  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic {ST_WAIT, ST_RUN} state_e;

  state_e        state_q;
  logic          own_vld_q;
  logic          own_id_q;
  logic          rr_last_q;
  logic [CW-1:0] burst_cnt_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic [1:0]    tag_vld_q;
  logic [1:0]    tag_id_q;

  logic [1:0]    req_w;
  logic [1:0]    lock_w;
  logic [AW-1:0] addr_w [2];
  logic          gnt_vld;
  logic          gnt_id;
  logic          gnt_forced;
  logic          own_vld_d;
  logic          own_id_d;
  logic [CW-1:0] burst_cnt_d;
  logic [1:0]    gnt_w;
  logic [1:0]    rvalid_w;
  logic [DW-1:0] rdata_w [2];

  assign req_w     = {bus.req1, bus.req0};
  assign lock_w    = {bus.lock1, bus.lock0};
  assign addr_w[0] = bus.addr0;
  assign addr_w[1] = bus.addr1;

  always_comb begin
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    gnt_forced = 1'b0;
    if (state_q == ST_RUN) begin
      if (own_vld_q && req_w[own_id_q]) begin
        gnt_vld = 1'b1;
        if (burst_cnt_q < MAX_CNT || !req_w[~own_id_q]) begin
          gnt_id = own_id_q;
        end else begin
          gnt_id     = ~own_id_q;
          gnt_forced = 1'b1;
        end
      end else if (req_w[0] && req_w[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = ~rr_last_q;
      end else if (req_w[0]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req_w[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  // Burst count saturates so an uncontested owner can keep streaming indefinitely.
  always_comb begin
    own_vld_d   = own_vld_q;
    own_id_d    = own_id_q;
    burst_cnt_d = burst_cnt_q;
    if (gnt_vld) begin
      own_vld_d = lock_w[gnt_id];
      own_id_d  = gnt_id;
      if (own_vld_q && (gnt_id == own_id_q) && !gnt_forced) begin
        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + CW'(1);
      end else begin
        burst_cnt_d = CW'(1);
      end
    end else if (own_vld_q && !req_w[own_id_q]) begin
      own_vld_d   = 1'b0;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      own_vld_q   <= 1'b0;
      own_id_q    <= 1'b0;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      if (state_q == ST_WAIT && bus.gray_ready) begin
        state_q <= ST_RUN;
      end
      own_vld_q   <= own_vld_d;
      own_id_q    <= own_id_d;
      burst_cnt_q <= burst_cnt_d;
      mem_req_q   <= gnt_vld;
      if (gnt_vld) begin
        rr_last_q  <= gnt_id;
        mem_addr_q <= addr_w[gnt_id];
      end
      // Stage 0 lines up with mem_req, stage 1 with the returning mem_data.
      tag_vld_q <= {tag_vld_q[0], gnt_vld};
      tag_id_q  <= {tag_id_q[0], gnt_id};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt_w[gi]    = gnt_vld && (gnt_id == 1'(gi));
    assign rvalid_w[gi] = tag_vld_q[1] && (tag_id_q[1] == 1'(gi));
    assign rdata_w[gi]  = rvalid_w[gi] ? bus.mem_data : '0;
  end

  assign bus.gnt0     = gnt_w[0];
  assign bus.gnt1     = gnt_w[1];
  assign bus.rvalid0  = rvalid_w[0];
  assign bus.rvalid1  = rvalid_w[1];
  assign bus.rdata0   = rdata_w[0];
  assign bus.rdata1   = rdata_w[1];
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.busy     = own_vld_q | (|tag_vld_q);
endmodule

// File: tb/tb_gray_port_arbiter.sv
// Scoreboard bench for gray_port_arbiter: a reference arbitration model predicts
// grants, queues expected memory strobes and read returns, and compares every cycle.
module tb_gray_port_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXB = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gray_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  gray_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // Image store: one-cycle read latency, junk when not strobed.
  always @(posedge clk) bus.mem_data <= bus.mem_req ? mem_fn(bus.mem_addr) : 8'hA5;

  typedef struct { int due; int addr; } ma_t;
  typedef struct { int due; int id; int data; } rd_t;
  ma_t memq[$];
  rd_t rdq[$];
  int  hist[$];

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  m_run = 0;
  int  m_owner = -1;
  int  m_rr = 1;
  int  m_cnt = 0;
  int  m_maddr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drv(input bit rst, input bit rdy, input bit r0, input bit l0, input int a0,
                     input bit r1, input bit l1, input int a1);
    reset          = rst;
    bus.gray_ready = rdy;
    bus.req0       = r0;
    bus.lock0      = l0;
    bus.addr0      = AW'(a0);
    bus.req1       = r1;
    bus.lock1      = l1;
    bus.addr1      = AW'(a1);
  endtask

  task automatic step();
    int  rq[2];
    int  lk[2];
    int  ad[2];
    int  eg;
    bit  ef;
    bit  rs;
    bit  rdy;
    bit  e_busy;
    bit  emr;
    bit  ev0;
    bit  ev1;
    int  ed;
    rd_t e;
    #3;
    rq[0] = int'(bus.req0);  rq[1] = int'(bus.req1);
    lk[0] = int'(bus.lock0); lk[1] = int'(bus.lock1);
    ad[0] = int'(bus.addr0); ad[1] = int'(bus.addr1);
    rs = reset; rdy = bus.gray_ready;
    eg = -1; ef = 1'b0;
    if (m_run) begin
      if (m_owner >= 0 && rq[m_owner] != 0) begin
        if (m_cnt < MAXB || rq[1 - m_owner] == 0) eg = m_owner;
        else begin eg = 1 - m_owner; ef = 1'b1; end
      end else if (rq[0] != 0 && rq[1] != 0) eg = 1 - m_rr;
      else if (rq[0] != 0) eg = 0;
      else if (rq[1] != 0) eg = 1;
    end
    e_busy = (m_owner >= 0) || (memq.size() > 0 && memq[0].due == cyc) ||
             (rdq.size() > 0 && rdq[0].due == cyc);
    chk("busy", bus.busy, e_busy);
    chk("gnt0", bus.gnt0, eg == 0);
    chk("gnt1", bus.gnt1, eg == 1);
    emr = memq.size() > 0 && memq[0].due == cyc;
    if (emr) begin
      m_maddr = memq[0].addr;
      void'(memq.pop_front());
    end
    chk("mem_req", bus.mem_req, emr);
    chk("mem_addr", bus.mem_addr, m_maddr);
    ev0 = 1'b0; ev1 = 1'b0; ed = 0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e = rdq.pop_front();
      if (e.id == 0) ev0 = 1'b1; else ev1 = 1'b1;
      ed = e.data;
      $display("cycle %0d: read return req%0d data=0x%02h", cyc, e.id, e.data);
    end
    chk("rvalid0", bus.rvalid0, ev0);
    chk("rvalid1", bus.rvalid1, ev1);
    chk("rdata0", bus.rdata0, ev0 ? ed : 0);
    chk("rdata1", bus.rdata1, ev1 ? ed : 0);
    hist.push_back(bus.gnt0 ? (bus.gnt1 ? 2 : 0) : (bus.gnt1 ? 1 : -1));
    @(posedge clk);
    if (rs) begin
      m_run = 0; m_owner = -1; m_rr = 1; m_cnt = 0; m_maddr = 0;
      memq.delete(); rdq.delete();
    end else if (!m_run) begin
      if (rdy) m_run = 1;
    end else if (eg >= 0) begin
      m_cnt   = (eg == m_owner && !ef) ? m_cnt + 1 : 1;
      m_owner = (lk[eg] != 0) ? eg : -1;
      m_rr    = eg;
      memq.push_back('{cyc + 1, ad[eg]});
      rdq.push_back('{cyc + 2, eg, int'(mem_fn(AW'(ad[eg])))});
    end else if (m_owner >= 0 && rq[m_owner] == 0) begin
      m_owner = -1; m_cnt = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drv(0, rdy, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
  endtask

  task automatic chk_hist(input string tag, input int exp[$]);
    chk({tag, "_len"}, hist.size() >= exp.size(), 1);
    for (int i = 0; i < exp.size() && i < hist.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), hist[i], exp[i]);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Held off until gray_ready is seen
    do_reset();
    hist.delete();
    for (int i = 0; i < 5; i++) begin drv(0, 0, 1, 0, 'h0081, 0, 0, 0); step(); end
    drv(0, 1, 1, 0, 'h0081, 0, 0, 0); step();
    drv(0, 1, 1, 0, 'h0081, 0, 0, 0); step();
    idle(3, 1);
    chk_hist("ready_hold", '{-1, -1, -1, -1, -1, -1, 0});

    // Round-robin with both requesting
    do_reset();
    idle(1, 1);
    hist.delete();
    for (int i = 0; i < 6; i++) begin drv(0, 1, 1, 0, 'h0100 + i, 1, 0, 'h0200 + i); step(); end
    idle(3, 1);
    chk_hist("rr", '{0, 1, 0, 1, 0, 1});

    // Locked burst bounded by MAX_BURST
    do_reset();
    idle(1, 1);
    hist.delete();
    for (int i = 0; i < 14; i++) begin drv(0, 1, 1, 1, 'h0300 + i, 1, 0, 'h2000 + i); step(); end
    idle(3, 1);
    chk_hist("burst", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});

    // Lock released on the third grant
    do_reset();
    idle(1, 1);
    hist.delete();
    drv(0, 1, 1, 1, 'h0010, 1, 0, 'h1000); step();
    drv(0, 1, 1, 1, 'h0011, 1, 0, 'h1000); step();
    drv(0, 1, 1, 0, 'h0012, 1, 0, 'h1000); step();
    drv(0, 1, 0, 0, 'h0000, 1, 0, 'h1000); step();
    idle(3, 1);
    chk_hist("lock_rel", '{0, 0, 0, 1});

    // Data steering across requesters
    do_reset();
    idle(1, 1);
    hist.delete();
    drv(0, 1, 0, 0, 'h0000, 1, 0, 'h3F80); step();
    drv(0, 1, 1, 0, 'h0000, 0, 0, 'h0000); step();
    idle(3, 1);
    chk_hist("steer", '{1, 0});

    // Reset while reads are in flight, then no grant without gray_ready
    do_reset();
    idle(1, 1);
    hist.delete();
    for (int i = 0; i < 3; i++) begin drv(0, 1, 1, 1, 'h0040 + i, 0, 0, 0); step(); end
    drv(1, 0, 1, 1, 'h0043, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin drv(0, 0, 1, 0, 'h0044, 0, 0, 0); step(); end
    chk_hist("rst_mid", '{0, 0, 0, 0, -1, -1, -1, -1});
    idle(2, 0);

    // Random traffic
    do_reset();
    idle(1, 1);
    for (int i = 0; i < 80; i++) begin
      drv(0, 1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 16383)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 16383)));
      step();
    end
    idle(4, 1);
    chk("sb_empty", memq.size() + rdq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
